bcd_convert_ctrl: RTL

- Sequential binary-to-BCD converter controller using iterative double-dabble (shift-add-3).
- Accepts a 16-bit binary value on a start/busy/done handshake and produces four registered BCD digits (ones..thousands) plus an overflow flag.
- Sits between the counter/measurement logic and the seven-segment display driver.
- Time-multiplexes one adjust/shift step over IN_WIDTH cycles, replacing a wide combinational converter.

---
 rtl/bcd_convert_ctrl_pkg.sv | 27 ++
 rtl/bcd_convert_ctrl_if.sv | 26 ++
 rtl/bcd_convert_ctrl_dabble_step.sv | 25 ++
 rtl/bcd_convert_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/bcd_convert_ctrl_pkg.sv
// Shared types and constants for the binary-to-BCD converter controller.
package bcd_convert_ctrl_pkg;

  // Controller states: wait for a request, run one double-dabble step per
  // cycle, then publish the result for one cycle.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Largest value representable in the four published digits.
  localparam int unsigned BCD_MAX        = 9999;
  // Internal digits: five are enough for any 16-bit input (65535).
  localparam int unsigned BCD_DIGITS     = 5;
  localparam int unsigned BCD_W          = 4 * BCD_DIGITS;
  // A digit at or above this value would exceed 9 after doubling.
  localparam logic [3:0]  ADD3_THRESHOLD = 4'd5;
  // Digit value shown on every position when a result is saturated.
  localparam logic [3:0]  DIGIT_MAX      = 4'd9;

  // Pre-shift correction of one BCD digit.
  function automatic logic [3:0] f_add3(input logic [3:0] i_nib);
    return (i_nib >= ADD3_THRESHOLD) ? i_nib + 4'd3 : i_nib;
  endfunction

endpackage

// File: rtl/bcd_convert_ctrl_if.sv
// Request/result bundle between the converter and its client.
interface bcd_convert_ctrl_if #(
  parameter int unsigned IN_WIDTH = 16
);
  logic                start;
  logic [IN_WIDTH-1:0] y;
  logic                busy;
  logic                done;
  logic [3:0]          ones;
  logic [3:0]          tens;
  logic [3:0]          hundreds;
  logic [3:0]          thousands;
  logic                overflow;

  // Client side: issues requests, observes status and digits.
  modport master (
    output start, y,
    input  busy, done, ones, tens, hundreds, thousands, overflow
  );

  // Converter side.
  modport slave (
    input  start, y,
    output busy, done, ones, tens, hundreds, thousands, overflow
  );
endinterface

// File: rtl/bcd_convert_ctrl_dabble_step.sv
// One combinational double-dabble iteration: add 3 to every digit >= 5,
// then shift the whole BCD field left by one, inserting the next binary bit.
module bcd_convert_ctrl_dabble_step
  import bcd_convert_ctrl_pkg::*;
(
  input  logic [BCD_W-1:0] i_bcd,
  input  logic             i_serial,
  output logic [BCD_W-1:0] o_bcd,
  output logic             o_carry
);

  logic [BCD_W-1:0] w_adj;

  // Per-digit correction ahead of the shift.
  always_comb begin
    w_adj = '0;
    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
      w_adj[4*i +: 4] = f_add3(i_bcd[4*i +: 4]);
    end
  end

  // The bit leaving the top digit is reported rather than silently dropped.
  assign {o_carry, o_bcd} = {w_adj, i_serial};

endmodule

// File: rtl/bcd_convert_ctrl.sv
// Sequential binary-to-BCD converter: one shift-add-3 step per cycle over
// IN_WIDTH cycles, four registered digits plus an overflow flag.
module bcd_convert_ctrl
  import bcd_convert_ctrl_pkg::*;
#(
  parameter int unsigned IN_WIDTH = 16,
  parameter bit          SATURATE = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  bcd_convert_ctrl_if.slave      bus
);

  localparam int unsigned      CNT_W    = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_WIDTH - 1);

  state_t              r_state;
  logic [IN_WIDTH-1:0] r_bin;
  logic [BCD_W-1:0]    r_bcd;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_lost;
  logic                r_busy;
  logic                r_done;
  logic                r_overflow;
  logic [3:0]          r_ones;
  logic [3:0]          r_tens;
  logic [3:0]          r_hundreds;
  logic [3:0]          r_thousands;

  logic [BCD_W-1:0]    w_bcd_next;
  logic                w_carry;
  logic                w_overflow;
  logic [15:0]         w_digits;

  bcd_convert_ctrl_dabble_step u_step (
    .i_bcd    (r_bcd),
    .i_serial (r_bin[IN_WIDTH-1]),
    .o_bcd    (w_bcd_next),
    .o_carry  (w_carry)
  );

  // Final result selection from the completed BCD field. r_lost can only be
  // set if the field were too narrow for the input; it is folded into
  // overflow so a truncated value is never reported as valid.
  always_comb begin
    w_overflow = (r_bcd[BCD_W-1 -: 4] != 4'd0) || r_lost;
    if (SATURATE && w_overflow) begin
      w_digits = {4{DIGIT_MAX}};
    end else begin
      w_digits = r_bcd[15:0];
    end
  end

  // Controller FSM with registered status and result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_bin       <= '0;
      r_bcd       <= '0;
      r_cnt       <= '0;
      r_lost      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
      r_ones      <= '0;
      r_tens      <= '0;
      r_hundreds  <= '0;
      r_thousands <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_bin   <= bus.y;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_lost  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_bcd  <= w_bcd_next;
          r_bin  <= {r_bin[IN_WIDTH-2:0], 1'b0};
          r_lost <= r_lost | w_carry;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_ones      <= w_digits[3:0];
          r_tens      <= w_digits[7:4];
          r_hundreds  <= w_digits[11:8];
          r_thousands <= w_digits[15:12];
          r_overflow  <= w_overflow;
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.ones      = r_ones;
  assign bus.tens      = r_tens;
  assign bus.hundreds  = r_hundreds;
  assign bus.thousands = r_thousands;
  assign bus.overflow  = r_overflow;

endmodule
